// File: rtl/sim_tohost_ctrl.sv
// Simulation test-control responder: TOHOST pass/fail word, STATUS/CYCLE read window,
// a signature RAM and a run-cycle watchdog, all behind a simple word store/load port.
module sim_tohost_ctrl #(
  parameter logic [31:0] CTRL_BASE      = 32'h8000_1000,
  parameter logic [31:0] SIG_BASE       = 32'h8000_2000,
  parameter int          SIG_DEPTH      = 64,
  parameter int          TIMEOUT_CYCLES = 50000,
  localparam int         AW             = (SIG_DEPTH > 1) ? $clog2(SIG_DEPTH) : 1,
  localparam int         CW             = $clog2(SIG_DEPTH) + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          wr_en,
  input  logic [31:0]   wr_addr,
  input  logic [31:0]   wr_data,
  input  logic          rd_en,
  input  logic [31:0]   rd_addr,
  output logic [31:0]   rd_data,
  output logic          test_done,
  output logic          test_pass,
  output logic [30:0]   fail_num,
  output logic          timeout,
  output logic [31:0]   cycle_cnt,
  output logic [CW-1:0] sig_count,
  input  logic [AW-1:0] sig_rd_idx,
  output logic [31:0]   sig_rd_data
);

  typedef enum logic [1:0] {S_RUN, S_DONE, S_TIMEOUT} state_t;

  typedef struct packed {
    logic          tohost;
    logic          status;
    logic          cycle;
    logic          sig;
    logic [AW-1:0] idx;
  } dec_t;

  localparam logic [31:0] SIG_BYTES = 32'(4 * SIG_DEPTH);

  state_t      state;
  logic [31:0] tohost_q;
  logic [31:0] sig_mem [SIG_DEPTH];
  dec_t        wdec, rdec;
  logic        running, done_store, timeout_hit;
  logic [31:0] rd_mux;
  logic [CW-1:0] wr_cnt;

  // Byte offset into the signature window; addresses below SIG_BASE wrap high and miss.
  function automatic dec_t decode(input logic [31:0] addr);
    logic [31:0] w, off;
    dec_t d;
    w        = {addr[31:2], 2'b00};
    off      = w - SIG_BASE;
    d.tohost = (w == CTRL_BASE);
    d.status = (w == CTRL_BASE + 32'd4);
    d.cycle  = (w == CTRL_BASE + 32'd8);
    d.sig    = (off < SIG_BYTES);
    d.idx    = off[2 +: AW];
    return d;
  endfunction

  assign wdec        = decode(wr_addr);
  assign rdec        = decode(rd_addr);
  assign running     = (state == S_RUN);
  assign done_store  = running && wr_en && wdec.tohost && wr_data[0];
  assign timeout_hit = (cycle_cnt == 32'(TIMEOUT_CYCLES - 1));
  assign wr_cnt      = CW'(wdec.idx) + CW'(1);
  assign sig_rd_data = sig_mem[sig_rd_idx];

  always_comb begin
    rd_mux = 32'd0;
    if (rdec.tohost)      rd_mux = tohost_q;
    else if (rdec.status) rd_mux = {29'd0, timeout, test_pass, test_done};
    else if (rdec.cycle)  rd_mux = cycle_cnt;
    else if (rdec.sig)    rd_mux = sig_mem[rdec.idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_RUN;
      test_done <= 1'b0;
      test_pass <= 1'b0;
      fail_num  <= 31'd0;
      timeout   <= 1'b0;
      cycle_cnt <= 32'd0;
      rd_data   <= 32'd0;
      sig_count <= '0;
      tohost_q  <= 32'd0;
    end else begin
      if (rd_en) rd_data <= rd_mux;
      if (running) begin
        if (wr_en && wdec.tohost) tohost_q <= wr_data;
        if (wr_en && wdec.sig && wr_cnt > sig_count) sig_count <= wr_cnt;
        // A done-store in the watchdog's last cycle still counts as done.
        if (done_store) begin
          state     <= S_DONE;
          test_done <= 1'b1;
          test_pass <= (wr_data == 32'd1);
          fail_num  <= (wr_data == 32'd1) ? 31'd0 : wr_data[31:1];
          cycle_cnt <= cycle_cnt + 32'd1;
        end else if (timeout_hit) begin
          state   <= S_TIMEOUT;
          timeout <= 1'b1;
        end else begin
          cycle_cnt <= cycle_cnt + 32'd1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (!rst && running && wr_en && wdec.sig) sig_mem[wdec.idx] <= wr_data;
  end

endmodule

// File: tb/tb_sim_tohost_ctrl.sv
// Randomized bench for sim_tohost_ctrl: reference model of the protocol rules, a per-cycle
// compare process, and directed literal checks for the pass/fail/timeout/signature scenarios.
module tb_sim_tohost_ctrl;
  localparam logic [31:0] CTRL = 32'h8000_1000;
  localparam logic [31:0] SIGB = 32'h8000_2000;
  localparam int DEPTH = 16;
  localparam int TMO   = 300;

  logic clk = 0, rst = 1;
  logic wr_en = 0, rd_en = 0;
  logic [31:0] wr_addr = 0, wr_data = 0, rd_addr = 0, rd_data;
  logic test_done, test_pass, timeout;
  logic [30:0] fail_num;
  logic [31:0] cycle_cnt, sig_rd_data;
  logic [4:0] sig_count;
  logic [3:0] sig_rd_idx = 0;

  int checks = 0, errors = 0;
  bit chk_en = 0;

  sim_tohost_ctrl #(.CTRL_BASE(CTRL), .SIG_BASE(SIGB), .SIG_DEPTH(DEPTH), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .rst(rst), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data), .test_done(test_done),
    .test_pass(test_pass), .fail_num(fail_num), .timeout(timeout), .cycle_cnt(cycle_cnt),
    .sig_count(sig_count), .sig_rd_idx(sig_rd_idx), .sig_rd_data(sig_rd_data));

  always #5 clk = ~clk;

  // Reference model state
  bit m_done, m_pass, m_to, m_tohost_v, m_rd_v;
  logic [30:0] m_fail;
  int unsigned m_cnt, m_sigcnt;
  logic [31:0] m_tohost, m_rd;
  logic [31:0] m_sig [DEPTH];
  bit m_sigv [DEPTH];

  function automatic bit in_sig(input logic [31:0] a);
    return (a >= SIGB) && (a < SIGB + 32'(4 * DEPTH));
  endfunction

  always @(posedge clk) begin : model
    logic [31:0] ra, wa;
    int i;
    if (rst) begin
      m_done = 0; m_pass = 0; m_to = 0; m_fail = 0; m_cnt = 0; m_sigcnt = 0;
      m_tohost_v = 0; m_rd = 0; m_rd_v = 1;
      for (int k = 0; k < DEPTH; k++) m_sigv[k] = 0;
    end else begin
      ra = {rd_addr[31:2], 2'b00};
      wa = {wr_addr[31:2], 2'b00};
      if (rd_en) begin
        m_rd_v = 1;
        if (ra == CTRL) begin m_rd = m_tohost; m_rd_v = m_tohost_v; end
        else if (ra == CTRL + 4) m_rd = {29'd0, m_to, m_pass, m_done};
        else if (ra == CTRL + 8) m_rd = m_cnt;
        else if (in_sig(ra)) begin i = int'((ra - SIGB) / 4); m_rd = m_sig[i]; m_rd_v = m_sigv[i]; end
        else m_rd = 0;
      end
      if (!m_done && !m_to) begin
        if (wr_en && wa == CTRL) begin m_tohost = wr_data; m_tohost_v = 1; end
        if (wr_en && in_sig(wa)) begin
          i = int'((wa - SIGB) / 4);
          m_sig[i] = wr_data; m_sigv[i] = 1;
          if (i + 1 > int'(m_sigcnt)) m_sigcnt = i + 1;
        end
        if (wr_en && wa == CTRL && wr_data[0]) begin
          m_done = 1; m_pass = (wr_data == 1); m_fail = m_pass ? 31'd0 : wr_data[31:1];
          m_cnt++;
        end else if (m_cnt == TMO - 1) m_to = 1;
        else m_cnt++;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) if (chk_en) begin
    chk("test_done", 32'(test_done), 32'(m_done));
    chk("test_pass", 32'(test_pass), 32'(m_pass));
    chk("fail_num", 32'(fail_num), 32'(m_fail));
    chk("timeout", 32'(timeout), 32'(m_to));
    chk("cycle_cnt", cycle_cnt, m_cnt);
    chk("sig_count", 32'(sig_count), m_sigcnt);
    if (m_rd_v) chk("rd_data", rd_data, m_rd);
    if (m_sigv[sig_rd_idx]) chk("sig_rd_data", sig_rd_data, m_sig[sig_rd_idx]);
  end

  task automatic step(input bit r, input bit we, input logic [31:0] wa, input logic [31:0] wd,
                      input bit re, input logic [31:0] ra);
    rst = r; wr_en = we; wr_addr = wa; wr_data = wd; rd_en = re; rd_addr = ra;
    sig_rd_idx = 4'($urandom_range(0, DEPTH - 1));
    @(posedge clk); #2;
  endtask

  function automatic logic [31:0] rand_addr();
    case ($urandom_range(0, 6))
      0: return CTRL;
      1: return CTRL + 4 + 32'($urandom_range(0, 3));
      2: return CTRL + 8;
      3: return CTRL + 12;
      4: return SIGB + 32'(4 * DEPTH) + 32'(4 * $urandom_range(0, 7));
      5: return SIGB - 4;
      default: return SIGB + 32'($urandom_range(0, 4 * DEPTH - 1));
    endcase
  endfunction

  task automatic rand_op(input bit allow_done);
    logic [31:0] wa, wd;
    wa = rand_addr();
    wd = $urandom;
    if (wa[31:2] == CTRL[31:2] && !allow_done) wd[0] = 0;
    step(0, $urandom_range(0, 1), wa, wd, $urandom_range(0, 1), rand_addr());
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    step(1, 0, 0, 0, 0, 0);
    chk_en = 1;
    step(1, 1, CTRL, 32'h1, 1, CTRL);
    chk("rst_done", 32'(test_done), 0);
    chk("rst_cycle", cycle_cnt, 0);
    chk("rst_rd", rd_data, 0);
    chk("rst_sigcnt", 32'(sig_count), 0);

    // Non-done TOHOST store, readback, STATUS
    step(0, 1, CTRL, 32'h2, 0, 0);
    step(0, 0, 0, 0, 1, CTRL);
    chk("tohost_rd", rd_data, 32'h2);
    step(0, 0, 0, 0, 1, CTRL + 4);
    chk("status_rd", rd_data, 0);
    chk("nodone", 32'(test_done), 0);

    // Signature fill, rewrite, out-of-range drop
    for (int k = 0; k < 4; k++) step(0, 1, SIGB + 32'(4 * k), 32'hA + 32'(k), 0, 0);
    step(0, 1, SIGB + 4, 32'hE, 0, 0);
    step(0, 1, SIGB + 32'(4 * DEPTH), 32'hDEAD, 0, 0);
    chk("sig_count4", 32'(sig_count), 4);
    sig_rd_idx = 0; #1 chk("sig0", sig_rd_data, 32'hA);
    sig_rd_idx = 1; #1 chk("sig1", sig_rd_data, 32'hE);
    sig_rd_idx = 2; #1 chk("sig2", sig_rd_data, 32'hC);
    sig_rd_idx = 3; #1 chk("sig3", sig_rd_data, 32'hD);
    for (int k = 0; k < 80; k++) rand_op(0);

    // Pass at cycle 100
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 200 && m_cnt != 100; k++) rand_op(0);
    chk("reach100", m_cnt, 100);
    step(0, 1, CTRL, 32'h1, 0, 0);
    chk("pass_done", 32'(test_done), 1);
    chk("pass_pass", 32'(test_pass), 1);
    chk("pass_fail", 32'(fail_num), 0);
    for (int k = 0; k < 30; k++) rand_op(1);
    chk("pass_frozen", cycle_cnt, 101);

    // Fail code, then a later pass store is ignored; store in rst cycle ignored
    step(1, 1, CTRL, 32'h7, 0, 0);
    chk("rst2_done", 32'(test_done), 0);
    step(0, 1, CTRL, 32'h7, 0, 0);
    chk("fail_done", 32'(test_done), 1);
    chk("fail_pass", 32'(test_pass), 0);
    chk("fail_num3", 32'(fail_num), 3);
    chk("fail_cycle", cycle_cnt, 1);
    step(0, 1, CTRL, 32'h1, 0, 0);
    chk("late_pass", 32'(test_pass), 0);
    chk("late_fail", 32'(fail_num), 3);

    // Timeout
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400 && !m_to; k++) rand_op(0);
    chk("to_flag", 32'(timeout), 1);
    chk("to_cycle", cycle_cnt, TMO - 1);
    chk("to_done", 32'(test_done), 0);
    for (int k = 0; k < 10; k++) rand_op(1);

    // Done-store in the timeout cycle wins
    step(1, 0, 0, 0, 0, 0);
    for (int k = 0; k < 400 && m_cnt != TMO - 1; k++) step(0, 0, 0, 0, 1, CTRL + 8);
    step(0, 1, CTRL, 32'h5, 0, 0);
    chk("race_done", 32'(test_done), 1);
    chk("race_to", 32'(timeout), 0);
    chk("race_fail", 32'(fail_num), 2);
    chk("race_cycle", cycle_cnt, TMO);

    // Same-cycle store+load returns old value; rd_data holds
    step(1, 0, 0, 0, 0, 0);
    step(0, 1, SIGB + 12, 32'h11, 0, 0);
    step(0, 1, SIGB + 12, 32'h22, 1, SIGB + 12);
    chk("sig_old", rd_data, 32'h11);
    step(0, 1, CTRL, 32'h4, 0, 0);
    step(0, 1, CTRL, 32'h6, 1, CTRL);
    chk("tohost_old", rd_data, 32'h4);
    step(0, 0, 0, 0, 0, CTRL);
    chk("rd_hold", rd_data, 32'h4);

    // Random soak with occasional resets
    for (int k = 0; k < 300; k++) begin
      if ($urandom_range(0, 49) == 0) step(1, $urandom_range(0, 1), rand_addr(), $urandom, 1, rand_addr());
      else rand_op($urandom_range(0, 9) == 0);
    end

    chk_en = 0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
